xup_and5_sweep_ctrl: RTL
========================

XUP_AND5_SWEEP_CTRL -- requirements
Module: xup_and5_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 4, sets the number of cycles each vector is held before sampling; legal range 1..255.
REQ-002 Parameter HALT_ON_ERR, default 0; when 1, the sweep stops at the first mismatch.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level-sampled request to begin a sweep.
REQ-006 vec_out  output  5  drives the five inputs of the 5-input AND under test: bit4=a, bit3=b, bit2=c, bit1=d, bit0=e.
REQ-007 gate_y  input  1  output of the gate under test.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high while in DONE state, until the next start or reset.
REQ-010 pass  output  1  high when done=1 and err_count=0.
REQ-011 err_count  output  6  number of mismatching vectors in the last sweep (0..32).
REQ-012 fail_valid  output  1  high once any mismatch has been recorded in the current sweep.
REQ-013 first_fail  output  5  vector value of the first mismatch; meaningful only when fail_valid=1.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, CHECK and DONE.
REQ-015 In IDLE or DONE, start=1 at a clock edge SHALL move the FSM to SETTLE with vec_out=0, settle counter=0, err_count=0, fail_valid=0, first_fail=0, busy=1, done=0.
REQ-016 start SHALL be ignored in SETTLE and CHECK.
REQ-017 In SETTLE, the counter SHALL increment each cycle and move to CHECK on the edge where it equals SETTLE-1, holding vec_out for SETTLE cycles.
REQ-018 CHECK SHALL last one cycle, and at its closing edge the expected value SHALL be the AND of all five vec_out bits.
REQ-019 At the closing edge of CHECK, a gate_y mismatch SHALL increment err_count; if fail_valid=0, it SHALL also set fail_valid=1 and load first_fail with vec_out.
REQ-020 After a CHECK with vec_out<31 (and no halt), vec_out SHALL increment by 1 and the FSM SHALL return to SETTLE with the counter cleared.
REQ-021 After a CHECK with vec_out=31, the FSM SHALL enter DONE, with busy=0 and done=1; vec_out SHALL hold at 31 and is not allowed to wrap.
REQ-022 With HALT_ON_ERR=1, a mismatch in CHECK SHALL go straight to DONE with vec_out held at the failing vector.
REQ-023 A full sweep SHALL take exactly 32*(SETTLE+1) cycles from the start-sampling edge to the edge that asserts done.
REQ-024 err_count SHALL be 6 bits wide so that 32 mismatches are counted without overflow.
REQ-025 pass SHALL be derived combinationally from done and err_count, and all other outputs SHALL be registered.

Reset
REQ-026 reset=1 at any edge SHALL force IDLE with vec_out=0, busy=0, done=0, err_count=0, fail_valid=0, first_fail=0 and settle counter=0.
REQ-027 A reset in the middle of a sweep SHALL abort it with no residual result, and reset SHALL take priority over start on the same edge.

Structure
REQ-028 The state enumeration and the constants NUM_VEC=32 and VEC_W=5 SHALL live in the shared package xup_gate_test_pkg.
REQ-029 The settle counter SHALL be the sub-module xup_settle_timer, with inputs clk, reset, load and outputs expired; its width SHALL come from SETTLE.
REQ-030 The gate under test SHALL be instantiated outside this block, and the controller SHALL contain no gate primitives.

Verification
REQ-031 SETTLE=4, ideal model (gate_y = AND of vec_out), pulse start -> done rises 160 cycles after the start edge, pass=1, err_count=0, fail_valid=0.
REQ-032 gate_y stuck at 0 -> err_count=1, first_fail=31, fail_valid=1, pass=0.
REQ-033 gate_y stuck at 1 -> err_count=31, first_fail=0, pass=0.
REQ-034 HALT_ON_ERR=1, gate_y stuck at 1, SETTLE=4 -> done rises 5 cycles after the start edge, vec_out=0, err_count=1.
REQ-035 reset asserted while vec_out=10 -> next cycle IDLE with all outputs 0; a new start then completes normally in 160 cycles.
REQ-036 start held high for the whole sweep -> no restart mid-sweep; the sweep restarts on the edge after DONE is entered.

Source files
------------

// File: rtl/xup_gate_test_pkg.sv
// xup_gate_test_pkg: shared states and constants for the 5-input gate sweep controller
package xup_gate_test_pkg;
  localparam int NUM_VEC = 32;
  localparam int VEC_W = 5;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;
endpackage

// File: rtl/xup_settle_timer.sv
// xup_settle_timer: counts cycles since load was released, flags the last settle cycle
module xup_settle_timer #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);
  localparam int W = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [W-1:0] LAST = W'(SETTLE - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) r_cnt <= (reset || load) ? '0 : r_cnt + 1'b1;
  assign expired = r_cnt == LAST;
endmodule

// File: rtl/xup_and5_sweep_ctrl.sv
// xup_and5_sweep_ctrl: sweeps all 32 input vectors through an external 5-input AND and tallies mismatches
module xup_and5_sweep_ctrl
  import xup_gate_test_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       gate_y,
  output logic [4:0] vec_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic       fail_valid,
  output logic [4:0] first_fail
);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  state_t r_state;
  logic [VEC_W-1:0] r_vec, r_ff;
  logic [5:0] r_err;
  logic r_busy, r_done, r_fv;
  logic w_expired, w_mis, w_last;
  assign w_mis = gate_y != &r_vec;
  assign w_last = r_vec == LAST_VEC || (HALT_ON_ERR && w_mis);
  // timer runs only while settling, so it is already cleared on every entry to SETTLE
  xup_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(r_state != S_SETTLE),
    .expired(w_expired)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_vec <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= '0;
      r_fv <= 1'b0;
      r_ff <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_state <= S_SETTLE;
          r_vec <= '0;
          r_busy <= 1'b1;
          r_done <= 1'b0;
          r_err <= '0;
          r_fv <= 1'b0;
          r_ff <= '0;
        end
        S_SETTLE: if (w_expired) r_state <= S_CHECK;
        S_CHECK: begin
          if (w_mis) begin
            r_err <= r_err + 1'b1;
            if (!r_fv) begin
              r_fv <= 1'b1;
              r_ff <= r_vec;
            end
          end
          if (w_last) begin
            r_state <= S_DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_state <= S_SETTLE;
            r_vec <= r_vec + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign vec_out = r_vec;
  assign busy = r_busy;
  assign done = r_done;
  assign err_count = r_err;
  assign fail_valid = r_fv;
  assign first_fail = r_ff;
  assign pass = r_done && r_err == '0;
endmodule
